// File: rtl/fb_serial_mac_bank.sv
// Time-multiplexed FIR bank: one shared delay line and a single MAC walk
// CHANNELS x TAPS runtime-writable coefficients, emitting one saturated result per channel.
module fb_serial_mac_bank #(
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned TAPS     = 120,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned OUT_W    = 33,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clk_enable,
  input  logic signed [DATA_W-1:0]             in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 coef_we,
  input  logic [$clog2(CHANNELS*TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]             coef_wdata,
  output logic                                 coef_busy,
  output logic signed [OUT_W-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]          out_ch,
  output logic                                 out_valid,
  output logic                                 out_sat
);

  localparam int unsigned NCOEF  = CHANNELS * TAPS;
  localparam int unsigned ADDR_W = $clog2(NCOEF);
  localparam int unsigned K_W    = $clog2(TAPS);
  localparam int unsigned CH_W   = $clog2(CHANNELS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int unsigned EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [1:0]  DRAIN_LAST = 2'd2;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_next;
  logic   accept_c, run_last_c, wr_en_c;

  logic [K_W-1:0]    k_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        drain_q;

  logic signed [DATA_W-1:0] taps_q [TAPS];
  logic [COEF_W-1:0]        coef_ram [NCOEF];

  logic                     s1_valid, s1_first, s1_last;
  logic [CH_W-1:0]          s1_ch;
  logic signed [DATA_W-1:0] tap_q;
  logic signed [COEF_W-1:0] coef_q;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_q, acc_sh_c;
  logic signed [EXT_W-1:0]  y_ext_c;
  logic                     acc_done_q;
  logic [CH_W-1:0]          acc_ch_q;
  logic                     sat_hi_c, sat_lo_c;

  // Next-state logic
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
    run_last_c = (ch_q == CH_W'(CHANNELS-1)) && (k_q == K_W'(TAPS-1));
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN:   if (run_last_c) state_next = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      coef_busy <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_next;
      in_ready  <= (state_next == S_IDLE);
      coef_busy <= (state_next != S_IDLE);
    end
  end

  // Tap/channel/address walk; drain counts the pipeline flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_q       <= '0;
      ch_q      <= '0;
      rd_addr_q <= '0;
      drain_q   <= '0;
    end else if (clk_enable) begin
      if (accept_c) begin
        k_q       <= '0;
        ch_q      <= '0;
        rd_addr_q <= '0;
      end else if (state_q == S_RUN && !run_last_c) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (k_q == K_W'(TAPS-1)) begin
          k_q  <= '0;
          ch_q <= ch_q + CH_W'(1);
        end else begin
          k_q <= k_q + K_W'(1);
        end
      end
      if (state_q == S_RUN)        drain_q <= '0;
      else if (state_q == S_DRAIN) drain_q <= drain_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) taps_q[i] <= '0;
    end else if (clk_enable && accept_c) begin
      taps_q[0] <= in_data;
      for (int i = 1; i < int'(TAPS); i++) taps_q[i] <= taps_q[i-1];
    end
  end

  // Coefficient RAM: writes land only while idle, read port feeds stage 1
  assign wr_en_c = coef_we && (state_q == S_IDLE) && (32'(coef_addr) < NCOEF);

  always_ff @(posedge clock) begin
    if (clk_enable) begin
      if (wr_en_c) coef_ram[coef_addr] <= coef_wdata;
      coef_q <= coef_ram[rd_addr_q];
    end
  end

  // Stage 1: tap select and control alongside the RAM read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_ch    <= '0;
      tap_q    <= '0;
    end else if (clk_enable) begin
      s1_valid <= (state_q == S_RUN);
      s1_first <= (k_q == '0);
      s1_last  <= (k_q == K_W'(TAPS-1));
      s1_ch    <= ch_q;
      tap_q    <= taps_q[k_q];
    end
  end

  // Stage 2: full-precision multiply-accumulate, restarted at tap 0
  assign prod_c = tap_q * coef_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
      acc_ch_q   <= '0;
    end else if (clk_enable) begin
      if (s1_valid) acc_q <= (s1_first ? ACC_W'(0) : acc_q) + ACC_W'(prod_c);
      acc_done_q <= s1_valid && s1_last;
      acc_ch_q   <= s1_ch;
    end
  end

  // Stage 3: scale, clamp and register the channel result
  assign acc_sh_c = acc_q >>> SHIFT;
  assign y_ext_c  = EXT_W'(acc_sh_c);
  assign sat_hi_c = (y_ext_c > SAT_MAX);
  assign sat_lo_c = (y_ext_c < SAT_MIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (clk_enable) begin
      out_valid <= acc_done_q;
      if (acc_done_q) begin
        out_ch  <= acc_ch_q;
        out_sat <= sat_hi_c || sat_lo_c;
        if (sat_hi_c)      out_data <= OUT_W'(SAT_MAX);
        else if (sat_lo_c) out_data <= OUT_W'(SAT_MIN);
        else               out_data <= OUT_W'(y_ext_c);
      end
    end
  end

endmodule

// File: tb/tb_fb_serial_mac_bank.sv
// Directed bench for fb_serial_mac_bank in a small configuration
// (TAPS=6, CHANNELS=4, OUT_W=20) so every scenario fits a short run.
module tb_fb_serial_mac_bank;

  localparam int TAPS = 6;
  localparam int CHN  = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic signed [12:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               coef_busy;
  logic signed [19:0] out_data;
  logic [1:0]         out_ch;
  logic               out_valid;
  logic               out_sat;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     nv;
  int     t_ready;
  int     res_t [CHN];
  longint res_d [CHN];
  longint res_s [CHN];
  longint res_c [CHN];

  fb_serial_mac_bank #(
    .DATA_W(13), .COEF_W(16), .TAPS(TAPS), .CHANNELS(CHN), .OUT_W(20), .SHIFT(0)
  ) dut (
    .clock(clock), .reset(reset), .clk_enable(clk_enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_busy(coef_busy), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_sat(out_sat)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wcoef(input logic [4:0] a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    tick;
    coef_we = 1'b0;
  endtask

  // Offer one sample (optionally with a same-cycle coefficient write); returns just after E0
  task automatic send(input logic signed [12:0] d, input logic we,
                      input logic [4:0] a, input logic signed [15:0] wd);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin tick; w++; end
    chk("send ready", longint'(in_ready), 1);
    in_data = d; in_valid = 1'b1;
    coef_we = we; coef_addr = a; coef_wdata = wd;
    tick;
    in_valid = 1'b0; coef_we = 1'b0; in_data = '0;
    chk("accept busy", longint'(coef_busy), 1);
  endtask

  // Collect strobes (cycle offset from E0) until in_ready returns
  task automatic capture(input int t0, input int stall_at, input int stall_len,
                         input int hold_at, input logic signed [12:0] hold_d);
    int t;
    t = t0; nv = 0; t_ready = -1;
    for (int c = 0; c < CHN; c++) res_t[c] = -1;
    while (t < 100 && t_ready < 0) begin
      if (t == hold_at) begin in_data = hold_d; in_valid = 1'b1; end
      if (stall_len > 0 && t == stall_at) clk_enable = 1'b0;
      if (stall_len > 0 && t == stall_at + stall_len) clk_enable = 1'b1;
      tick;
      t++;
      if (out_valid) begin
        if (nv < CHN) begin
          res_t[nv] = t;
          res_d[nv] = longint'(out_data);
          res_s[nv] = longint'(out_sat);
          res_c[nv] = longint'(out_ch);
        end
        nv++;
      end
      if (in_ready) t_ready = t;
    end
  endtask

  task automatic check_times(input string tag, input int stall_at, input int stall_len);
    int e;
    chk({tag, " strobes"}, longint'(nv), longint'(CHN));
    for (int c = 0; c < CHN; c++) begin
      e = (c + 1) * TAPS + 2;
      if (stall_len > 0 && e > stall_at) e += stall_len;
      chk($sformatf("%s time ch%0d", tag, c), longint'(res_t[c]), longint'(e));
      chk($sformatf("%s out_ch %0d", tag, c), res_c[c], longint'(c));
    end
    e = CHN * TAPS + 3 + stall_len;
    chk({tag, " ready time"}, longint'(t_ready), longint'(e));
  endtask

  task automatic check_val(input string tag, input int c, input longint d, input longint s);
    chk($sformatf("%s data ch%0d", tag, c), res_d[c], d);
    chk($sformatf("%s sat ch%0d", tag, c), res_s[c], s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b1; clk_enable = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    tick; tick;
    reset = 1'b0;
    tick;

    chk("rst in_ready", longint'(in_ready), 1);
    chk("rst coef_busy", longint'(coef_busy), 0);
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst out_data", longint'(out_data), 0);
    chk("rst out_ch", longint'(out_ch), 0);
    chk("rst out_sat", longint'(out_sat), 0);

    // coef[c][k] = c*256 + k
    for (int c = 0; c < CHN; c++)
      for (int k = 0; k < TAPS; k++)
        wcoef(5'(c * TAPS + k), 16'(c * 256 + k));

    // Impulse: sample 0 also carries the timing check and a held next sample
    send(13'sd1, 1'b0, 5'd0, 16'sd0);
    capture(0, -1, 0, 5, 13'sd0);
    check_times("imp n0", -1, 0);
    for (int c = 0; c < CHN; c++) check_val("imp n0", c, longint'(c * 256), 0);
    chk("hold out_valid", longint'(out_valid), 0);
    chk("hold out_data", longint'(out_data), 768);
    chk("hold out_ch", longint'(out_ch), 3);
    chk("held in_valid ready", longint'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("held sample accepted", longint'(in_ready), 0);
    capture(0, -1, 0, -1, 13'sd0);
    check_times("imp n1", -1, 0);
    for (int c = 0; c < CHN; c++) check_val("imp n1", c, longint'(c * 256 + 1), 0);
    for (int n = 2; n <= TAPS; n++) begin
      send(13'sd0, 1'b0, 5'd0, 16'sd0);
      capture(0, -1, 0, -1, 13'sd0);
      for (int c = 0; c < CHN; c++)
        check_val($sformatf("imp n%0d", n), c, (n < TAPS) ? longint'(c * 256 + n) : 0, 0);
    end

    // Coefficient lock: write 100 while idle, attempt 7 while running
    wcoef(5'd0, 16'sd100);
    send(13'sd0, 1'b0, 5'd0, 16'sd0);
    coef_we = 1'b1; coef_addr = 5'd0; coef_wdata = 16'sd7;
    chk("lock busy", longint'(coef_busy), 1);
    tick;
    coef_we = 1'b0;
    capture(1, -1, 0, -1, 13'sd0);
    // Same-cycle write to coef[1][0] alongside the impulse
    send(13'sd1, 1'b1, 5'd6, 16'sd55);
    capture(0, -1, 0, -1, 13'sd0);
    check_val("lock", 0, 100, 0);
    check_val("samecyc", 1, 55, 0);
    check_val("lock", 2, 512, 0);
    check_val("lock", 3, 768, 0);

    // clk_enable low for 10 cycles mid-run: taps now [0,1,0,...]
    send(13'sd0, 1'b0, 5'd0, 16'sd0);
    capture(0, 10, 10, -1, 13'sd0);
    check_times("stall", 10, 10);
    for (int c = 0; c < CHN; c++) check_val("stall", c, longint'(c * 256 + 1), 0);

    // Asynchronous reset mid-run
    send(13'sd1, 1'b0, 5'd0, 16'sd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick; if (out_valid) cnt++; end
    chk("pre-reset strobes", longint'(cnt), 1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    chk("abort in_ready", longint'(in_ready), 1);
    chk("abort out_valid", longint'(out_valid), 0);
    chk("abort coef_busy", longint'(coef_busy), 0);
    chk("abort out_data", longint'(out_data), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin tick; if (out_valid) cnt++; end
    chk("abort no strobes", longint'(cnt), 0);
    wcoef(5'd0, 16'sd0);
    wcoef(5'd6, 16'sd256);
    send(13'sd1, 1'b0, 5'd0, 16'sd0);
    capture(0, -1, 0, -1, 13'sd0);
    check_times("post-reset", -1, 0);
    for (int c = 0; c < CHN; c++) check_val("post-reset", c, longint'(c * 256), 0);

    // Saturation: 6*4095*32767 and 6*(-4096)*32767 both exceed 20-bit range
    for (int a = 0; a < CHN * TAPS; a++) wcoef(5'(a), 16'sd32767);
    for (int n = 0; n < TAPS; n++) begin
      send(13'sd4095, 1'b0, 5'd0, 16'sd0);
      capture(0, -1, 0, -1, 13'sd0);
    end
    check_val("sat pos", 0, 524287, 1);
    check_val("sat pos", 3, 524287, 1);
    for (int n = 0; n < TAPS; n++) begin
      send(13'h1000, 1'b0, 5'd0, 16'sd0);
      capture(0, -1, 0, -1, 13'sd0);
    end
    check_val("sat neg", 0, -524288, 1);
    check_val("sat neg", 3, -524288, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
